// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, ALU control codes and FSM states for the 8-bit processor
package proc_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_JMP  = 8'h03;
  localparam logic [7:0] OP_JZ   = 8'h04;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic ALU_PASS_B = 1'b0;
  localparam logic ALU_ADD    = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_OPERAND,
    ST_EXECUTE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/accum_ctrl_if.sv
// rtl/accum_ctrl_if.sv - instruction memory read port and ALU operand/result bus
interface accum_ctrl_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_ctrl;
  logic [7:0] alu_out;

  modport master (
    output imem_addr, alu_a, alu_b, alu_ctrl,
    input  imem_data, alu_out
  );

  modport slave (
    input  imem_addr, alu_a, alu_b, alu_ctrl,
    output imem_data, alu_out
  );
endinterface

// File: rtl/accum_ctrl_decode.sv
// rtl/accum_ctrl_decode.sv - combinational opcode classifier; JZ decoded only under ACCUM_CTRL_JZ_EN
module accum_ctrl_decode
  import proc_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_two_byte,
  output logic       alu_ctrl,
  output logic       is_jump,
  output logic       is_cond,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_two_byte = 1'b0;
    alu_ctrl    = ALU_PASS_B;
    is_jump     = 1'b0;
    is_cond     = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_LDI:  is_two_byte = 1'b1;
      OP_ADDI: begin
        is_two_byte = 1'b1;
        alu_ctrl    = ALU_ADD;
      end
      OP_JMP: begin
        is_two_byte = 1'b1;
        is_jump     = 1'b1;
      end
`ifdef ACCUM_CTRL_JZ_EN
      OP_JZ: begin
        is_two_byte = 1'b1;
        is_jump     = 1'b1;
        is_cond     = 1'b1;
      end
`endif
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - fetch/decode/execute controller owning pc and accumulator
// Optional JZ instruction enabled by defining ACCUM_CTRL_JZ_EN.
module accum_ctrl
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  accum_ctrl_if.master     bus,
  output logic [7:0]       acc,
  output logic [7:0]       pc,
  output logic             halted,
  output logic             illegal
);

  state_t     state;
  logic [7:0] ir;
  logic [7:0] opr;
  logic [7:0] last_addr;
  logic       alu_ctrl_q;
  logic [7:0] addr;

  logic [7:0] dec_op;
  logic       d_two_byte, d_alu_ctrl, d_jump, d_cond, d_halt, d_illegal;

  // DECODE classifies the byte arriving from memory; later states use the latched ir.
  assign dec_op = (state == ST_DECODE) ? bus.imem_data : ir;

  accum_ctrl_decode u_decode (
    .opcode      (dec_op),
    .is_two_byte (d_two_byte),
    .alu_ctrl    (d_alu_ctrl),
    .is_jump     (d_jump),
    .is_cond     (d_cond),
    .is_halt     (d_halt),
    .is_illegal  (d_illegal)
  );

  always_comb begin
    addr = pc;
    case (state)
      ST_DECODE: addr = d_two_byte ? pc + 8'd1 : pc;
      ST_HALT:   addr = last_addr;
      default:   addr = pc;
    endcase
  end

  assign bus.imem_addr = addr;
  assign bus.alu_a     = acc;
  assign bus.alu_b     = opr;
  assign bus.alu_ctrl  = alu_ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      pc         <= 8'd0;
      acc        <= 8'd0;
      ir         <= 8'd0;
      opr        <= 8'd0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      alu_ctrl_q <= ALU_PASS_B;
      last_addr  <= 8'd0;
    end else if (en) begin
      last_addr <= addr;
      case (state)
        ST_FETCH: begin
          alu_ctrl_q <= ALU_PASS_B;
          state      <= ST_DECODE;
        end
        ST_DECODE: begin
          ir <= bus.imem_data;
          if (d_illegal) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else if (d_halt) begin
            pc     <= pc + 8'd1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (d_two_byte) begin
            state <= ST_OPERAND;
          end else begin
            pc    <= pc + 8'd1;
            state <= ST_FETCH;
          end
        end
        ST_OPERAND: begin
          opr        <= bus.imem_data;
          alu_ctrl_q <= d_alu_ctrl;
          state      <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          alu_ctrl_q <= ALU_PASS_B;
          if (d_jump) begin
            pc <= (!d_cond || acc == 8'd0) ? opr : pc + 8'd2;
          end else begin
            acc <= bus.alu_out;
            pc  <= pc + 8'd2;
          end
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
